// File: rtl/clk_enable_sched.sv
// clk_enable_sched: emulated-time event scheduler producing TX / RX clock-enable
// pulses for the gated-clock generator. Each enabled cycle jumps emulated time
// to the earliest pending edge and fires every enable due at that instant.
module clk_enable_sched #(
  parameter int unsigned TIME_W = 32,
  parameter int unsigned PER_W  = 24,
  parameter int unsigned ADJ_W  = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              en,
  input  logic [PER_W-1:0]  tx_period,
  input  logic [PER_W-1:0]  rx_half_period,
  input  logic [ADJ_W-1:0]  rx_adj,
  input  logic              rx_adj_valid,
  output logic              rx_adj_ack,
  output logic              cke_tx,
  output logic              cke_rx_p,
  output logic              cke_rx_n,
  output logic [TIME_W-1:0] emu_time,
  output logic [PER_W-1:0]  emu_dt
);

  // Schedule state
  logic [TIME_W-1:0] t_tx;
  logic [TIME_W-1:0] t_rx;
  logic              rx_ph;
  logic [ADJ_W-1:0]  adj_pend;
  logic              adj_full;

  // Next-state values
  logic [TIME_W-1:0] t_tx_nxt;
  logic [TIME_W-1:0] t_rx_nxt;
  logic              rx_ph_nxt;
  logic [ADJ_W-1:0]  adj_pend_nxt;
  logic              adj_full_nxt;
  logic [TIME_W-1:0] time_nxt;
  logic [PER_W-1:0]  dt_nxt;
  logic              cke_tx_nxt;
  logic              cke_rx_p_nxt;
  logic              cke_rx_n_nxt;
  logic              ack_nxt;

  // Datapath intermediates
  logic [PER_W-1:0]  tx_eff;
  logic [PER_W-1:0]  rx_eff;
  logic [TIME_W-1:0] d_tx;
  logic [TIME_W-1:0] d_rx;
  logic [TIME_W-1:0] d_min;
  logic              fire_tx;
  logic              fire_rx;
  logic [TIME_W-1:0] adj_ext;
  logic [TIME_W-1:0] rx_step_raw;
  logic [TIME_W-1:0] rx_step;

  // Effective periods, modular distances to each edge and the RX reschedule step
  always_comb begin
    tx_eff  = (tx_period == '0) ? PER_W'(1) : tx_period;
    rx_eff  = (rx_half_period == '0) ? PER_W'(1) : rx_half_period;
    d_tx    = t_tx - emu_time;
    d_rx    = t_rx - emu_time;
    d_min   = (d_tx <= d_rx) ? d_tx : d_rx;
    fire_tx = (d_tx == d_min);
    fire_rx = (d_rx == d_min);
    adj_ext = adj_full ? {{(TIME_W-ADJ_W){adj_pend[ADJ_W-1]}}, adj_pend} : '0;
    rx_step_raw = TIME_W'(rx_eff) + adj_ext;
    // MSB set means the adjusted step went negative (legal steps stay below half range)
    rx_step = (rx_step_raw[TIME_W-1] || (rx_step_raw == '0)) ? TIME_W'(1) : rx_step_raw;
  end

  // Next-state / next-output computation for one scheduling step
  always_comb begin
    time_nxt     = emu_time;
    dt_nxt       = emu_dt;
    t_tx_nxt     = t_tx;
    t_rx_nxt     = t_rx;
    rx_ph_nxt    = rx_ph;
    adj_pend_nxt = adj_pend;
    adj_full_nxt = adj_full;
    cke_tx_nxt   = 1'b0;
    cke_rx_p_nxt = 1'b0;
    cke_rx_n_nxt = 1'b0;
    ack_nxt      = 1'b0;

    if (en) begin
      time_nxt     = emu_time + d_min;
      dt_nxt       = d_min[PER_W-1:0];
      cke_tx_nxt   = fire_tx;
      cke_rx_p_nxt = fire_rx & ~rx_ph;
      cke_rx_n_nxt = fire_rx & rx_ph;
      if (fire_tx) begin
        t_tx_nxt = t_tx + TIME_W'(tx_eff);
      end
      if (fire_rx) begin
        t_rx_nxt     = t_rx + rx_step;
        rx_ph_nxt    = ~rx_ph;
        ack_nxt      = adj_full;
        adj_full_nxt = 1'b0;
      end
    end

    // A new adjustment wins over consumption: it becomes the next pending value
    if (rx_adj_valid) begin
      adj_pend_nxt = rx_adj;
      adj_full_nxt = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      emu_time   <= '0;
      emu_dt     <= '0;
      t_tx       <= TIME_W'(tx_eff);
      t_rx       <= TIME_W'(rx_eff);
      rx_ph      <= 1'b0;
      adj_pend   <= '0;
      adj_full   <= 1'b0;
      cke_tx     <= 1'b0;
      cke_rx_p   <= 1'b0;
      cke_rx_n   <= 1'b0;
      rx_adj_ack <= 1'b0;
    end else begin
      emu_time   <= time_nxt;
      emu_dt     <= dt_nxt;
      t_tx       <= t_tx_nxt;
      t_rx       <= t_rx_nxt;
      rx_ph      <= rx_ph_nxt;
      adj_pend   <= adj_pend_nxt;
      adj_full   <= adj_full_nxt;
      cke_tx     <= cke_tx_nxt;
      cke_rx_p   <= cke_rx_p_nxt;
      cke_rx_n   <= cke_rx_n_nxt;
      rx_adj_ack <= ack_nxt;
    end
  end

endmodule

// File: doc/clk_enable_sched.md
# clk_enable_sched

Event scheduler that generates the TX and RX clock-enable pulses (`cke_tx`, `cke_rx_p`, `cke_rx_n`) consumed by the gated-clock generator. It keeps a modular emulated-time counter plus the next-edge time of the TX clock and of the RX clock. Each enabled `clk_sys` cycle, it advances emulated time to the earliest pending edge and asserts the enables of every clock edge due at that time. An RX phase-adjust port lets the CDR loop shift the RX edge schedule.

## Interface
- `TIME_W`, 32: width of emulated-time counters; arithmetic is modulo 2^TIME_W.
- `PER_W`, 24: width of period inputs (unsigned); `PER_W < TIME_W`.
- `ADJ_W`, 16: width of the signed RX phase adjustment; `ADJ_W <= PER_W`.
- `clk_sys`  in  1  system clock (ungated); only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  advance emulated time this cycle.
- `tx_period`  in  PER_W  TX clock period in time units.
- `rx_half_period`  in  PER_W  RX half period; rising and falling RX edges alternate at this spacing.
- `rx_adj`  in  ADJ_W  signed RX edge shift.
- `rx_adj_valid`  in  1  `rx_adj` is valid this cycle.
- `rx_adj_ack`  out  1  one-cycle pulse when a pending adjustment is consumed.
- `cke_tx`  out  1  TX edge enable.
- `cke_rx_p`  out  1  RX rising-edge enable.
- `cke_rx_n`  out  1  RX falling-edge enable.
- `emu_time`  out  TIME_W  emulated time of the current step.
- `emu_dt`  out  PER_W  time elapsed since the previous step.

## Operation
- State: `t_tx` (next TX edge), `t_rx` (next RX edge), `rx_ph` (0 means the next RX edge is rising), `adj_pend`/`adj_full`, and the registered outputs.
- Reset (`rst_n`=0 at a `clk_sys` edge):
  - `emu_time`=0, `emu_dt`=0.
  - `t_tx`=eff(`tx_period`), `t_rx`=eff(`rx_half_period`), `rx_ph`=0.
  - `adj_full`=0, `adj_pend`=0.
  - All `cke_*`=0, `rx_adj_ack`=0.
- eff(p) = max(p, 1); a zero period is treated as 1.
- Earliest edge: compare by modular distance from `emu_time`. `d_tx = t_tx - emu_time` and `d_rx = t_rx - emu_time`, both mod 2^TIME_W and unsigned. `m = emu_time + min(d_tx, d_rx)`.
- Enabled step (`en`=1):
  - `emu_time`<=m and `emu_dt`<=min(d_tx, d_rx).
  - `cke_tx`<=(d_tx==min).
  - `cke_rx_p`<=(d_rx==min && !rx_ph).
  - `cke_rx_n`<=(d_rx==min && rx_ph).
  - Simultaneous TX and RX edges assert both enables in the same cycle.
- TX fires: `t_tx` <= `t_tx` + eff(`tx_period`).
- RX fires:
  - `step` = eff(`rx_half_period`) + (`adj_full` ? sign-extended `adj_pend` : 0).
  - If `step` < 1, clamp `step` to 1.
  - `t_rx` <= `t_rx` + `step`; `rx_ph` toggles.
  - If `adj_full`, pulse `rx_adj_ack` and clear `adj_full`.
- Adjustment capture:
  - `rx_adj_valid`=1 loads `adj_pend` and sets `adj_full`, regardless of `en`.
  - A later valid before consumption overwrites the pending value (last wins).
  - Valid in the same cycle the pending value is consumed: the old value is applied and acked, and the new value becomes pending (`adj_full` stays 1).
- Period inputs are sampled only when the respective edge is rescheduled. Changes never move an already-scheduled edge.
- Disabled cycle (`en`=0): all `cke_*`=0, `rx_adj_ack`=0, and time and schedule are held.
- Legal range: eff(period) plus adjustment must stay < 2^(TIME_W-1). Behaviour outside this range is unspecified.

## Timing
- All outputs are registered. `cke_*`, `emu_time` and `emu_dt` update one `clk_sys` cycle after the enabled cycle that computed them.
- One scheduling step per enabled cycle, back-to-back, no bubbles.
- Every `cke_*` is high for exactly one cycle per scheduled edge. `rx_adj_ack` coincides with the `cke_rx_*` pulse of the adjusted edge.
- First enable pulse appears the cycle after the first `en`=1 following reset release.
- Reset mid-operation: all state returns to reset values at the next edge. Any pending adjustment is discarded without ack.
- Wrap-around: `emu_time` passing 2^TIME_W-1 to 0 causes no glitch. Ordering stays correct because it uses modular distances.

## Test plan
- Basic schedule: `tx_period`=10, `rx_half_period`=5, `en`=1 after reset.
  - Step 1: `emu_time`=5, `cke_rx_p`.
  - Step 2: time 10, `cke_tx` and `cke_rx_n` together.
  - Step 3: time 15, `cke_rx_p`.
  - Step 4: time 20, `cke_tx` and `cke_rx_n`.
  - `emu_dt`=5 on every step.
- Adjustment: same periods, `rx_adj`=+2 pulsed before step 1. The RX edge scheduled at step 1 lands at 12, not 10, with `rx_adj_ack` in that cycle. A `rx_adj` of -7 clamps the step to 1.
- Overwrite and collision:
  - Two valids (+3, then -1) before an RX edge: only -1 is applied.
  - Valid coinciding with consumption: the old value is applied, the new value is acked at the following RX edge.
- Enable gating: toggle `en` 1,0,0,1. No `cke_*` pulses and no time change while `en`=0, and the schedule resumes exactly.
- Wrap: force `emu_time` near 2^TIME_W-3 with periods 4/3. Edge order and `emu_dt` stay correct across zero.
- Reset mid-run and zero periods:
  - Assert `rst_n`=0 mid-sequence: outputs return to 0 and the schedule restarts at `t_tx`=10, `t_rx`=5.
  - `tx_period`=0 produces `cke_tx` every time unit.
